// File: rtl/ror_share_arbiter_if.sv
// ror_share_arbiter_if: groups the requester, shared-rotator and result-stage
// signals of ror_share_arbiter. The slave modport is the arbiter's view; the
// master modport is the surrounding environment (clients, rotator, consumer).
interface ror_share_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int SW    = 2
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic [SW-1:0]    req0_amt;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic [SW-1:0]    req1_amt;
  logic [WIDTH-1:0] rot_I;
  logic [SW-1:0]    rot_S;
  logic [WIDTH-1:0] rot_O;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_src;

  modport slave (
    input  req0_valid, req0_data, req0_amt,
    input  req1_valid, req1_data, req1_amt,
    input  rot_O, out_ready,
    output req0_ready, req1_ready,
    output rot_I, rot_S,
    output out_valid, out_data, out_src
  );

  modport master (
    output req0_valid, req0_data, req0_amt,
    output req1_valid, req1_data, req1_amt,
    output rot_O, out_ready,
    input  req0_ready, req1_ready,
    input  rot_I, rot_S,
    input  out_valid, out_data, out_src
  );
endinterface

// File: rtl/ror_share_arbiter.sv
// ror_share_arbiter: shares one external combinational rotate-right datapath
// between two valid/ready requesters and registers the rotator result plus a
// source tag into a one-entry output stage (one cycle of latency).
// Optional feature macro: ROR_ARB_FIXED_PRIO_EN -- when defined, contention is
// always won by requester 0 and the round-robin pointer is removed.
module ror_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int SW    = 2
) (
  input logic                CLK,
  input logic                RESETN,
  ror_share_arbiter_if.slave bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_outData;
  logic             r_outSrc;
  logic             r_lockValid;
  logic             r_lockSel;

  logic             w_acceptEn;
  logic             w_contendSel;
  logic             w_grantValid;
  logic             w_grantSel;
  logic             w_req0Ready;
  logic             w_req1Ready;
  logic             w_xfer;

`ifdef ROR_ARB_FIXED_PRIO_EN
  assign w_contendSel = 1'b0;
`else
  logic r_rrPtr;
  assign w_contendSel = r_rrPtr;
`endif

  assign w_acceptEn = (r_state == ST_EMPTY) | bus.out_ready;

  // Grant selection; a grant that stalled behind a full output stage stays locked until it transfers
  always_comb begin
    w_grantValid = 1'b0;
    w_grantSel   = 1'b0;
    if (r_lockValid) begin
      w_grantSel   = r_lockSel;
      w_grantValid = r_lockSel ? bus.req1_valid : bus.req0_valid;
    end else if (bus.req0_valid && bus.req1_valid) begin
      w_grantSel   = w_contendSel;
      w_grantValid = 1'b1;
    end else if (bus.req0_valid) begin
      w_grantSel   = 1'b0;
      w_grantValid = 1'b1;
    end else if (bus.req1_valid) begin
      w_grantSel   = 1'b1;
      w_grantValid = 1'b1;
    end
  end

  assign w_req0Ready = w_acceptEn & w_grantValid & ~w_grantSel & RESETN;
  assign w_req1Ready = w_acceptEn & w_grantValid &  w_grantSel & RESETN;
  assign w_xfer      = w_req0Ready | w_req1Ready;

  assign bus.req0_ready = w_req0Ready;
  assign bus.req1_ready = w_req1Ready;

  // Steer the granted operand and amount to the shared rotator, zeros when idle or in reset
  always_comb begin
    bus.rot_I = '0;
    bus.rot_S = '0;
    if (w_grantValid && RESETN) begin
      bus.rot_I = w_grantSel ? bus.req1_data : bus.req0_data;
      bus.rot_S = w_grantSel ? bus.req1_amt  : bus.req0_amt;
    end
  end

  // Output stage FSM: load on transfer, drain when the consumer takes the result with nothing new
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state   <= ST_EMPTY;
      r_outData <= '0;
      r_outSrc  <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_xfer) begin
            r_state   <= ST_FULL;
            r_outData <= bus.rot_O;
            r_outSrc  <= w_grantSel;
          end
        end
        ST_FULL: begin
          if (w_xfer) begin
            r_state   <= ST_FULL;
            r_outData <= bus.rot_O;
            r_outSrc  <= w_grantSel;
          end else if (bus.out_ready) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Remember a grant that could not transfer so a late-arriving request cannot steal it
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_lockValid <= 1'b0;
      r_lockSel   <= 1'b0;
    end else if (w_xfer || !w_grantValid) begin
      r_lockValid <= 1'b0;
    end else begin
      r_lockValid <= 1'b1;
      r_lockSel   <= w_grantSel;
    end
  end

`ifndef ROR_ARB_FIXED_PRIO_EN
  // Round-robin pointer favours the side that did not win the most recent transfer
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_rrPtr <= 1'b0;
    end else if (w_xfer) begin
      r_rrPtr <= ~w_grantSel;
    end
  end
`endif

  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_data  = r_outData;
  assign bus.out_src   = r_outSrc;

endmodule

// File: tb/tb_ror_share_arbiter.sv
// tb_ror_share_arbiter: self-checking bench for ror_share_arbiter. Provides a
// behavioural shared rotator and compares every cycle against a transaction
// level model of arbitration and the one-entry result stage.
module tb_ror_share_arbiter;

  logic CLK;
  logic RESETN;
  int   checks;
  int   failures;

  ror_share_arbiter_if #(.WIDTH(4), .SW(2)) bus ();

  ror_share_arbiter #(.WIDTH(4), .SW(2)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  // Rotate right by arithmetic on an integer: low bits wrap to the top
  function automatic logic [3:0] rorModel(input logic [3:0] d, input logic [1:0] a);
    int x;
    int s;
    x = int'(d);
    s = int'(a);
    return 4'(((x >> s) | (x << (4 - s))) & 15);
  endfunction

  assign bus.rot_O = rorModel(bus.rot_I, bus.rot_S);

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state
  logic       mValid;
  logic [3:0] mData;
  logic       mSrc;
  int         mFav;
  int         mLock;

  task automatic modelReset();
    mValid = 1'b0;
    mData  = 4'd0;
    mSrc   = 1'b0;
    mFav   = 0;
    mLock  = -1;
  endtask

  task automatic driveIdle();
    bus.req0_valid = 1'b0;
    bus.req0_data  = 4'd0;
    bus.req0_amt   = 2'd0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 4'd0;
    bus.req1_amt   = 2'd0;
    bus.out_ready  = 1'b0;
  endtask

  task automatic doReset();
    @(negedge CLK);
    driveIdle();
    RESETN = 1'b0;
    @(negedge CLK);
    RESETN = 1'b1;
    modelReset();
  endtask

  // One cycle: drive, check grant side outputs, clock, check result stage
  task automatic doStep(input string tag,
                        input logic v0, input logic [3:0] d0, input logic [1:0] a0,
                        input logic v1, input logic [3:0] d1, input logic [1:0] a1,
                        input logic oRdy, output logic acc0, output logic acc1);
    logic       acc;
    int         grant;
    logic [3:0] expI;
    logic [1:0] expS;
    @(negedge CLK);
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_amt = a0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_amt = a1;
    bus.out_ready  = oRdy;
    #1;
    acc = !mValid || oRdy;
    if (mLock >= 0) grant = mLock;
`ifdef ROR_ARB_FIXED_PRIO_EN
    else if (v0 && v1) grant = 0;
`else
    else if (v0 && v1) grant = mFav;
`endif
    else if (v0) grant = 0;
    else if (v1) grant = 1;
    else grant = -1;
    acc0 = acc && (grant == 0);
    acc1 = acc && (grant == 1);
    expI = (grant == 0) ? d0 : (grant == 1) ? d1 : 4'd0;
    expS = (grant == 0) ? a0 : (grant == 1) ? a1 : 2'd0;
    checks++;
    if (bus.req0_ready !== acc0) begin
      failures++;
      $display("[TB] FAIL %s req0_ready: got %b expected %b", tag, bus.req0_ready, acc0);
    end
    checks++;
    if (bus.req1_ready !== acc1) begin
      failures++;
      $display("[TB] FAIL %s req1_ready: got %b expected %b", tag, bus.req1_ready, acc1);
    end
    checks++;
    if (bus.rot_I !== expI || bus.rot_S !== expS) begin
      failures++;
      $display("[TB] FAIL %s rot_I/rot_S: got %b/%0d expected %b/%0d", tag, bus.rot_I, bus.rot_S, expI, expS);
    end
    @(posedge CLK);
    #1;
    if (grant >= 0 && acc) begin
      mValid = 1'b1;
      mData  = rorModel(expI, expS);
      mSrc   = (grant == 1);
      mFav   = 1 - grant;
      mLock  = -1;
    end else begin
      mLock = grant;
      if (acc) mValid = 1'b0;
    end
    checks++;
    if (bus.out_valid !== mValid) begin
      failures++;
      $display("[TB] FAIL %s out_valid: got %b expected %b", tag, bus.out_valid, mValid);
    end
    if (mValid) begin
      checks++;
      if (bus.out_data !== mData || bus.out_src !== mSrc) begin
        failures++;
        $display("[TB] FAIL %s out_data/out_src: got %b/%b expected %b/%b", tag, bus.out_data, bus.out_src, mData, mSrc);
      end
    end
  endtask

  task automatic test_reset();
    logic a0, a1;
    @(negedge CLK);
    RESETN = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 4'b0110; bus.req0_amt = 2'd1;
    bus.req1_valid = 1'b1; bus.req1_data = 4'b0101; bus.req1_amt = 2'd2;
    bus.out_ready  = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'd0 || bus.out_src !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset outputs: got v=%b d=%b s=%b expected 0/0000/0", bus.out_valid, bus.out_data, bus.out_src);
    end
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset readies: got %b%b expected 00", bus.req0_ready, bus.req1_ready);
    end
    checks++;
    if (bus.rot_I !== 4'd0 || bus.rot_S !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset rot: got %b/%0d expected 0000/0", bus.rot_I, bus.rot_S);
    end
    doReset();
    doStep("reset_idle", 1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b1, a0, a1);
  endtask

  task automatic test_req0_only();
    logic a0, a1;
    doReset();
    doStep("req0_only", 1'b1, 4'b0001, 2'd1, 1'b0, 4'd0, 2'd0, 1'b1, a0, a1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b1000 || bus.out_src !== 1'b0) begin
      failures++;
      $display("[TB] FAIL req0_only result: got v=%b d=%b s=%b expected 1/1000/0", bus.out_valid, bus.out_data, bus.out_src);
    end
    doStep("req0_drain", 1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b1, a0, a1);
  endtask

  task automatic test_passthrough();
    logic a0, a1;
    doStep("passthrough", 1'b0, 4'd0, 2'd0, 1'b1, 4'b1010, 2'd0, 1'b1, a0, a1);
    checks++;
    if (bus.out_data !== 4'b1010 || bus.out_src !== 1'b1) begin
      failures++;
      $display("[TB] FAIL passthrough result: got %b/%b expected 1010/1", bus.out_data, bus.out_src);
    end
    doStep("pass_drain", 1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b1, a0, a1);
  endtask

  task automatic test_contention();
    logic       a0, a1;
    logic [3:0] expD;
    logic       expSrc;
    doReset();
    for (int i = 0; i < 6; i++) begin
      doStep("contention", 1'b1, 4'b0011, 2'd2, 1'b1, 4'b1001, 2'd3, 1'b1, a0, a1);
`ifdef ROR_ARB_FIXED_PRIO_EN
      expSrc = 1'b0;
      expD   = 4'b1100;
`else
      expSrc = (i % 2 == 1);
      expD   = expSrc ? 4'b0011 : 4'b1100;
`endif
      checks++;
      if (bus.out_data !== expD || bus.out_src !== expSrc) begin
        failures++;
        $display("[TB] FAIL contention step %0d: got %b/%b expected %b/%b", i, bus.out_data, bus.out_src, expD, expSrc);
      end
    end
  endtask

  task automatic test_backpressure();
    logic a0, a1;
    doReset();
    doStep("bp_fill", 1'b1, 4'b0110, 2'd1, 1'b1, 4'b1110, 2'd2, 1'b1, a0, a1);
    for (int i = 0; i < 3; i++) begin
      doStep("bp_stall", 1'b1, 4'b0110, 2'd1, 1'b1, 4'b1110, 2'd2, 1'b0, a0, a1);
      checks++;
      if (bus.out_data !== 4'b0011 || bus.out_src !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_hold: got %b/%b expected 0011/0", bus.out_data, bus.out_src);
      end
    end
    doStep("bp_release", 1'b1, 4'b0110, 2'd1, 1'b1, 4'b1110, 2'd2, 1'b1, a0, a1);
`ifndef ROR_ARB_FIXED_PRIO_EN
    checks++;
    if (bus.out_data !== 4'b1011 || bus.out_src !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release load: got %b/%b expected 1011/1", bus.out_data, bus.out_src);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic a0, a1;
    doReset();
    doStep("ar_fill", 1'b1, 4'b0101, 2'd1, 1'b0, 4'd0, 2'd0, 1'b0, a0, a1);
    @(negedge CLK);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.out_ready  = 1'b1;
    #2;
    RESETN = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'd0) begin
      failures++;
      $display("[TB] FAIL async_reset outputs: got %b/%b expected 0/0000", bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset readies: got %b%b expected 00", bus.req0_ready, bus.req1_ready);
    end
    @(negedge CLK);
    driveIdle();
    RESETN = 1'b1;
    modelReset();
    doStep("ar_after", 1'b1, 4'b0001, 2'd3, 1'b1, 4'b1000, 2'd1, 1'b1, a0, a1);
  endtask

  task automatic test_random();
    logic       p0v, p1v, acc0, acc1, oRdy;
    logic [3:0] p0d, p1d;
    logic [1:0] p0a, p1a;
    doReset();
    p0v = 1'b0; p1v = 1'b0;
    p0d = 4'd0; p1d = 4'd0; p0a = 2'd0; p1a = 2'd0;
    for (int i = 0; i < 300; i++) begin
      if (!p0v) begin
        p0v = ($urandom_range(0, 2) != 0);
        p0d = 4'($urandom_range(0, 15));
        p0a = 2'($urandom_range(0, 3));
      end
      if (!p1v) begin
        p1v = ($urandom_range(0, 2) != 0);
        p1d = 4'($urandom_range(0, 15));
        p1a = 2'($urandom_range(0, 3));
      end
      oRdy = ($urandom_range(0, 3) != 0);
      doStep("random", p0v, p0d, p0a, p1v, p1d, p1a, oRdy, acc0, acc1);
      if (acc0) p0v = 1'b0;
      if (acc1) p1v = 1'b0;
    end
  endtask

  // Run every scenario in order and report
  initial begin
    checks   = 0;
    failures = 0;
    RESETN   = 1'b0;
    driveIdle();
    modelReset();
    test_reset();
    test_req0_only();
    test_passthrough();
    test_contention();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
